// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, keeps a credit-limited stream of
// in-order word reads in flight, buffers returns in a small FIFO and feeds decode.
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_de,
    input  logic        NextPCSrc,
    input  logic [31:0] alu_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_de,
    output logic [31:0] inst_de,
    output logic [31:0] pc_de,
    output logic [31:0] pcInc_de
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          valid_de_q, valid_de_d;
    logic [31:0]   inst_de_q, inst_de_d;
    logic [31:0]   pc_de_q, pc_de_d;

    logic [31:0]   fifo_pc_mem   [DEPTH];
    logic [31:0]   fifo_inst_mem [DEPTH];

    logic [31:0]   redirect_pc;
    logic          credit_ok;
    logic          accept;
    logic          keep;
    logic          load_head;
    logic          bypass;
    logic          push;

    logic          unused_alu_lsbs;
    assign unused_alu_lsbs = ^alu_out[1:0];

    always_comb begin
        redirect_pc = {alu_out[31:2], 2'b00};
        credit_ok   = ({1'b0, outstanding_q} + {1'b0, count_q}) < CREDITS;
        imem_req    = !NextPCSrc && credit_ok;
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
        keep        = imem_rvalid && !NextPCSrc && (drop_cnt_q == '0);
        load_head   = !NextPCSrc && en_de && (count_q != '0);
        // An empty FIFO lets a returning word go straight into decode.
        bypass      = !NextPCSrc && en_de && (count_q == '0) && keep;
        push        = keep && !bypass;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (NextPCSrc) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = outstanding_q - CW'(imem_rvalid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            // Responses return in order and sequentially, so one running PC tags them.
            if (keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (load_head) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(load_head);
        end

        valid_de_d = valid_de_q;
        inst_de_d  = inst_de_q;
        pc_de_d    = pc_de_q;
        if (NextPCSrc) begin
            valid_de_d = 1'b0;
            inst_de_d  = NOP;
        end else if (load_head) begin
            valid_de_d = 1'b1;
            inst_de_d  = fifo_inst_mem[rd_ptr_q];
            pc_de_d    = fifo_pc_mem[rd_ptr_q];
        end else if (bypass) begin
            valid_de_d = 1'b1;
            inst_de_d  = imem_rdata;
            pc_de_d    = resp_pc_q;
        end else if (en_de) begin
            valid_de_d = 1'b0;
            inst_de_d  = NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            valid_de_q    <= 1'b0;
            inst_de_q     <= NOP;
            pc_de_q       <= 32'h0000_0000;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            valid_de_q    <= valid_de_d;
            inst_de_q     <= inst_de_d;
            pc_de_q       <= pc_de_d;
        end
    end

    // Buffer storage needs no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_q]   <= resp_pc_q;
            fifo_inst_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign valid_de = valid_de_q;
    assign inst_de  = inst_de_q;
    assign pc_de    = pc_de_q;
    assign pcInc_de = pc_de_q + 32'd4;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model with latency/jitter and an
// architectural PC-stream reference for what must reach decode.
module tb_fetch_prefetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_de = 1'b1;
    logic        NextPCSrc = 1'b0;
    logic [31:0] alu_out = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        valid_de;
    logic [31:0] inst_de;
    logic [31:0] pc_de;
    logic [31:0] pcInc_de;

    fetch_prefetch #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .en_de(en_de), .NextPCSrc(NextPCSrc),
        .alu_out(alu_out), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_de(valid_de), .inst_de(inst_de), .pc_de(pc_de), .pcInc_de(pcInc_de)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          jit_en = 1'b0;
    int          last_due = -1;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_pc_de = RST_PC;
    bit          prev_en = 1'b1;
    bit          prev_redir = 1'b0;
    logic        prev_valid;
    logic [31:0] prev_inst, prev_pc;
    bit          new_seen = 1'b0;
    int          last_new_cyc = -1;
    logic [31:0] last_new_pc = 32'h0;
    logic        last_req = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ NOP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic step(input bit en, input bit redir, input logic [31:0] tgt, input bit rdy);
        bit acc;
        int due;
        en_de      = en;
        NextPCSrc  = redir;
        alu_out    = redir ? tgt : $urandom;
        imem_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        if (prev_redir) begin
            chk("valid_after_redirect", {31'b0, valid_de}, 32'h0);
        end else if (prev_en) begin
            if (valid_de) begin
                chk("de_pc", pc_de, exp_pc_de);
                chk("de_inst", inst_de, mem_word(exp_pc_de));
                chk("de_pcinc", pcInc_de, exp_pc_de + 32'd4);
                exp_pc_de    = exp_pc_de + 32'd4;
                new_seen     = 1'b1;
                last_new_cyc = cyc;
                last_new_pc  = pc_de;
            end else begin
                chk("idle_nop", inst_de, NOP);
            end
        end else begin
            chk("hold_valid", {31'b0, valid_de}, {31'b0, prev_valid});
            chk("hold_inst", inst_de, prev_inst);
            chk("hold_pc", pc_de, prev_pc);
        end
        last_req = imem_req;
        if (redir) chk("req_in_redirect", {31'b0, imem_req}, 32'h0);
        else if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
        acc = imem_req && rdy;
        if (acc) begin
            due = cyc + lat + (jit_en ? int'($urandom_range(0, 2)) : 0);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_addr, due: due});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc_de = {tgt[31:2], 2'b00};
        end
        prev_en    = en;
        prev_redir = redir;
        prev_valid = valid_de;
        prev_inst  = inst_de;
        prev_pc    = pc_de;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        NextPCSrc   = 1'b0;
        en_de       = 1'b1;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid_de}, 32'h0);
        chk("rst_inst", inst_de, NOP);
        chk("rst_pc", pc_de, 32'h0);
        chk("rst_pcinc", pcInc_de, 32'h4);
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, RST_PC);
        mq.delete();
        last_due   = -1;
        exp_fetch  = RST_PC;
        exp_pc_de  = RST_PC;
        prev_en    = 1'b1;
        prev_redir = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_new(input string tag, input int exp_c, input logic [31:0] exp_pc);
        int budget;
        budget   = 40;
        new_seen = 1'b0;
        while (!new_seen && budget > 0) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            budget--;
        end
        chk({tag, "_cycle"}, new_seen ? last_new_cyc : -1, exp_c);
        chk({tag, "_pc"}, last_new_pc, exp_pc);
    endtask

    task automatic run_random(input int n);
        bit redir;
        for (int i = 0; i < n; i++) begin
            redir = ($urandom % 40) == 0;
            if (redir) lat = int'($urandom_range(1, 3));
            step(($urandom % 4) != 0, redir,
                 (($urandom % 6) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom,
                 ($urandom % 3) != 0);
        end
    endtask

    initial begin
        int r;
        @(posedge clk);
        #1;
        do_reset();

        lat = 1;
        wait_new("first_valid", 2, RST_PC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_req_low", {31'b0, last_req}, 32'h0);
        chk("stall_hold_pc8", pc_de, 32'h8);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        lat = 3;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        r = cyc;
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        wait_new("redir_l3", r + 5, 32'h0000_0100);

        lat = 2;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 32'h0, cyc[0]);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        r = cyc;
        step(1'b1, 1'b1, 32'h0000_2000, 1'b1);
        wait_new("redir_coinc", r + 4, 32'h0000_2000);

        lat = 1;
        r = cyc;
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_new("wrap", r + 3, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_next_pc", last_new_pc, 32'h0000_0000);

        jit_en = 1'b1;
        run_random(2000);

        jit_en = 1'b0;
        lat    = 1;
        do_reset();
        wait_new("post_reset", 2, RST_PC);
        jit_en = 1'b1;
        run_random(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
